// File: rtl/lcd_fb_scheduler.sv
// Framebuffer for the SPI LCD driver. It serves registered pixel reads, accepts CPU writes
// and whole-screen clears, and schedules update/ready refresh handshakes while the buffer is dirty.
module lcd_fb_scheduler #(
    parameter int FB_W           = 60,
    parameter int FB_H           = 32,
    parameter int COLOR_W        = 4,
    parameter int AUTO_FLUSH     = 1,
    parameter int ACCEPT_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [5:0]         wr_x,
    input  logic [5:0]         wr_y,
    input  logic [COLOR_W-1:0] wr_color,
    input  logic               clear_req,
    input  logic [COLOR_W-1:0] clear_color,
    input  logic               flush,
    input  logic [5:0]         fb_x,
    input  logic [5:0]         fb_y,
    output logic [COLOR_W-1:0] fb_color,
    input  logic               lcd_ready,
    output logic               lcd_update,
    output logic               busy,
    output logic               dirty,
    output logic [15:0]        frame_count
);

    localparam int CELLS  = FB_W * FB_H;
    localparam int ADDR_W = $clog2(CELLS);
    localparam int TMR_W  = $clog2(ACCEPT_TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_REQ,
        S_WAIT_ACCEPT,
        S_WAIT_DONE
    } state_t;

    state_t state, state_next;

    logic [COLOR_W-1:0] mem [CELLS];

    logic               clear_pending;
    logic               flush_pending;
    logic [COLOR_W-1:0] clear_color_q;
    logic [ADDR_W-1:0]  clear_addr;
    logic [TMR_W-1:0]   timer;

    logic               wr_in_range;
    logic               rd_in_range;
    logic               wr_fire;
    logic               clear_done;
    logic               strobe;
    logic               timeout;
    logic               refresh_go;
    logic               flush_drop;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [COLOR_W-1:0] mem_wdata;
    logic [ADDR_W-1:0]  rd_addr;

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [5:0] x, input logic [5:0] y);
        return ADDR_W'(y) * ADDR_W'(FB_W) + ADDR_W'(x);
    endfunction

    assign wr_ready    = (state != S_CLEAR);
    assign busy        = (state != S_IDLE);
    assign wr_in_range = (wr_x < 6'(FB_W)) && (wr_y < 6'(FB_H));
    assign rd_in_range = (fb_x < 6'(FB_W)) && (fb_y < 6'(FB_H));
    assign wr_fire     = wr_valid && wr_ready && wr_in_range;
    assign clear_done  = (state == S_CLEAR) && (clear_addr == LAST_ADDR);
    assign strobe      = (state == S_REQ) && lcd_ready;
    assign timeout     = (state == S_WAIT_ACCEPT) && lcd_ready
                         && (timer == TMR_W'(ACCEPT_TIMEOUT - 1));
    assign refresh_go  = dirty && ((AUTO_FLUSH != 0) || flush_pending);
    // A flush that finds nothing to send is dropped rather than held for the next write.
    assign flush_drop  = (state == S_IDLE) && !clear_pending && flush_pending && !dirty;
    assign rd_addr     = cell_addr(fb_x, fb_y);

    // Single write port shared by the clear sweep and CPU writes; CPU writes are stalled during a clear.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        mem_we    = wr_fire;
        mem_waddr = cell_addr(wr_x, wr_y);
        mem_wdata = wr_color;
        if (state == S_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clear_addr;
            mem_wdata = clear_color_q;
        end
    end

    // NOTE: the pixel array has no reset; its contents survive rst, including a half-finished clear.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // A read of the address being written in the same cycle returns the old contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fb_color <= '0;
        end else if (rd_in_range) begin
            fb_color <= mem[rd_addr];
        end else begin
            fb_color <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (clear_pending) begin
                    state_next = S_CLEAR;
                end else if (refresh_go) begin
                    state_next = S_REQ;
                end
            end
            S_CLEAR:       if (clear_done) state_next = S_IDLE;
            S_REQ:         if (lcd_ready)  state_next = S_WAIT_ACCEPT;
            S_WAIT_ACCEPT: begin
                if (!lcd_ready) begin
                    state_next = S_WAIT_DONE;
                end else if (timeout) begin
                    state_next = S_REQ;
                end
            end
            S_WAIT_DONE:   if (lcd_ready)  state_next = S_IDLE;
            default:       state_next = S_IDLE;
        endcase
    end

    // Sticky flags use set-wins so a write landing on the strobe edge is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lcd_update    <= 1'b0;
            dirty         <= 1'b0;
            frame_count   <= '0;
            clear_pending <= 1'b0;
            flush_pending <= 1'b0;
            clear_color_q <= '0;
            clear_addr    <= '0;
            timer         <= '0;
        end else begin
            lcd_update    <= strobe;
            dirty         <= wr_fire || clear_done || timeout || (dirty && !strobe);
            clear_pending <= clear_req || (clear_pending && !clear_done);
            flush_pending <= flush || (flush_pending && !(strobe || flush_drop));
            if (clear_req) begin
                clear_color_q <= clear_color;
            end
            if ((state == S_CLEAR) && !clear_done) begin
                clear_addr <= clear_addr + 1'b1;
            end else begin
                clear_addr <= '0;
            end
            if (state == S_WAIT_ACCEPT) begin
                timer <= timer + 1'b1;
            end else begin
                timer <= '0;
            end
            if ((state == S_WAIT_DONE) && lcd_ready) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_fb_scheduler.sv
// Directed bench for lcd_fb_scheduler: one auto-flush instance plus one manual-flush instance,
// each driven by a simple LCD driver model.
module tb_lcd_fb_scheduler;

    localparam int ACCEPT_TIMEOUT = 64;
    localparam int DRV_BUSY       = 8;
    localparam int CELLS          = 60 * 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       wr_valid = 0, clear_req = 0, flush = 0, lcd_ready;
    logic [5:0] wr_x = 0, wr_y = 0, fb_x = 0, fb_y = 0;
    logic [3:0] wr_color = 0, clear_color = 0;
    logic       wr_ready, lcd_update, busy, dirty;
    logic [3:0] fb_color;
    logic [15:0] frame_count;

    logic       n_wr_valid = 0, n_flush = 0, n_lcd_ready;
    logic [5:0] n_wr_x = 0, n_wr_y = 0;
    logic [3:0] n_wr_color = 0;
    logic       n_wr_ready, n_lcd_update, n_busy, n_dirty;
    logic [3:0] n_fb_color;
    logic [15:0] n_frame_count;

    int checks = 0;
    int errors = 0;
    int upd_count = 0;
    int n_upd_count = 0;
    bit drv_auto = 1'b1;

    lcd_fb_scheduler #(.AUTO_FLUSH(1), .ACCEPT_TIMEOUT(ACCEPT_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
        .wr_color(wr_color), .clear_req(clear_req), .clear_color(clear_color), .flush(flush),
        .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color), .lcd_ready(lcd_ready),
        .lcd_update(lcd_update), .busy(busy), .dirty(dirty), .frame_count(frame_count)
    );

    lcd_fb_scheduler #(.AUTO_FLUSH(0), .ACCEPT_TIMEOUT(ACCEPT_TIMEOUT)) dut_manual (
        .clk(clk), .rst(rst), .wr_valid(n_wr_valid), .wr_ready(n_wr_ready), .wr_x(n_wr_x),
        .wr_y(n_wr_y), .wr_color(n_wr_color), .clear_req(1'b0), .clear_color(4'd0),
        .flush(n_flush), .fb_x(fb_x), .fb_y(fb_y), .fb_color(n_fb_color),
        .lcd_ready(n_lcd_ready), .lcd_update(n_lcd_update), .busy(n_busy), .dirty(n_dirty),
        .frame_count(n_frame_count)
    );

    // Driver models: drop ready on an update strobe, stay busy DRV_BUSY cycles, then raise it.
    initial begin
        int busy_cnt;
        busy_cnt = 0;
        lcd_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_cnt = 0;
                lcd_ready = 1'b1;
            end else begin
                if (lcd_update) upd_count++;
                if (busy_cnt > 0) begin
                    busy_cnt--;
                    if (busy_cnt == 0) lcd_ready = 1'b1;
                end else if (drv_auto && lcd_update) begin
                    lcd_ready = 1'b0;
                    busy_cnt = DRV_BUSY;
                end
            end
        end
    end

    initial begin
        int busy_cnt;
        busy_cnt = 0;
        n_lcd_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_cnt = 0;
                n_lcd_ready = 1'b1;
            end else begin
                if (n_lcd_update) n_upd_count++;
                if (busy_cnt > 0) begin
                    busy_cnt--;
                    if (busy_cnt == 0) n_lcd_ready = 1'b1;
                end else if (n_lcd_update) begin
                    n_lcd_ready = 1'b0;
                    busy_cnt = DRV_BUSY;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic write0(input int x, input int y, input int c);
        @(negedge clk);
        wr_valid = 1'b1; wr_x = 6'(x); wr_y = 6'(y); wr_color = 4'(c);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic write1(input int x, input int y, input int c);
        @(negedge clk);
        n_wr_valid = 1'b1; n_wr_x = 6'(x); n_wr_y = 6'(y); n_wr_color = 4'(c);
        @(negedge clk);
        n_wr_valid = 1'b0;
    endtask

    task automatic read0(input int x, input int y, output logic [3:0] c);
        @(negedge clk);
        fb_x = 6'(x); fb_y = 6'(y);
        @(negedge clk);
        c = fb_color;
    endtask

    task automatic wait_idle0(input int budget, input string name);
        int n;
        n = 0;
        while (!(busy == 1'b0 && dirty == 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_idle: still busy=%0b dirty=%0b after %0d cycles, required idle", name, busy, dirty, n);
        end
    endtask

    task automatic wait_pulse0(input int budget, input string name);
        int n;
        n = 0;
        while (lcd_update !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_pulse: no lcd_update within %0d cycles, required one", name, budget);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, wr_ready, lcd_update, dirty, frame_count, fb_color} !== {1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 4'd0}) begin
            errors++;
            $display("FAIL reset_outputs: busy=%0b wr_ready=%0b upd=%0b dirty=%0b frames=%0d color=%0d, required 0 1 0 0 0 0",
                     busy, wr_ready, lcd_update, dirty, frame_count, fb_color);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write_refresh();
        int u0;
        logic [3:0] c;
        u0 = upd_count;
        write0(3, 2, 5);
        checks++;
        if (dirty !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL t1_dirty: dirty=%0b busy=%0b, required 1 0", dirty, busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || lcd_update !== 1'b0) begin
            errors++; $display("FAIL t1_req: busy=%0b upd=%0b, required 1 0", busy, lcd_update);
        end
        @(negedge clk);
        checks++;
        if (lcd_update !== 1'b1 || dirty !== 1'b0) begin
            errors++; $display("FAIL t1_strobe: upd=%0b dirty=%0b, required 1 0", lcd_update, dirty);
        end
        @(negedge clk);
        checks++;
        if (lcd_update !== 1'b0) begin
            errors++; $display("FAIL t1_single: upd=%0b on second cycle, required 0", lcd_update);
        end
        read0(3, 2, c);
        checks++;
        if (c !== 4'd5) begin
            errors++; $display("FAIL t1_read: fb_color=%0d, required 5", c);
        end
        wait_idle0(100, "t1");
        checks++;
        if (frame_count !== 16'd1 || upd_count - u0 != 1) begin
            errors++; $display("FAIL t1_frames: frames=%0d pulses=%0d, required 1 1", frame_count, upd_count - u0);
        end
        // Same-cycle read and write of (3,2): old value first, new value one cycle later.
        @(negedge clk);
        wr_valid = 1'b1; wr_x = 6'd3; wr_y = 6'd2; wr_color = 4'd6;
        @(negedge clk);
        wr_valid = 1'b0;
        checks++;
        if (fb_color !== 4'd5) begin
            errors++; $display("FAIL t1_rdw_old: fb_color=%0d, required 5", fb_color);
        end
        @(negedge clk);
        checks++;
        if (fb_color !== 4'd6) begin
            errors++; $display("FAIL t1_rdw_new: fb_color=%0d, required 6", fb_color);
        end
        wait_idle0(100, "t1b");
    endtask

    task automatic test_clear();
        int u0, n, cnt, bad;
        logic [15:0] f0;
        logic [3:0] c;
        u0 = upd_count; f0 = frame_count;
        @(negedge clk);
        clear_req = 1'b1; clear_color = 4'd9;
        @(negedge clk);
        clear_req = 1'b0; clear_color = 4'd0;
        n = 0;
        while (wr_ready && n < 10) begin @(negedge clk); n++; end
        cnt = 0;
        while (!wr_ready && cnt < 4000) begin @(negedge clk); cnt++; end
        checks++;
        if (cnt != CELLS) begin
            errors++; $display("FAIL t2_stall: wr_ready low %0d cycles, required %0d", cnt, CELLS);
        end
        wait_idle0(200, "t2");
        checks++;
        if (upd_count - u0 != 1 || frame_count - f0 != 16'd1) begin
            errors++; $display("FAIL t2_refresh: pulses=%0d frames=%0d, required 1 1", upd_count - u0, frame_count - f0);
        end
        bad = 0;
        for (int y = 0; y < 32; y++) begin
            for (int x = 0; x < 60; x++) begin
                read0(x, y, c);
                if (c !== 4'd9) bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL t2_cells: %0d cells not 9, required 0", bad);
        end
    endtask

    task automatic test_write_during_done();
        int u0;
        logic [15:0] f0;
        logic [3:0] c;
        u0 = upd_count; f0 = frame_count;
        write0(10, 10, 3);
        wait_pulse0(20, "t4");
        write0(12, 10, 11);
        checks++;
        if (dirty !== 1'b1 || lcd_ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL t4_dirty: dirty=%0b ready=%0b busy=%0b, required 1 0 1", dirty, lcd_ready, busy);
        end
        wait_idle0(400, "t4");
        checks++;
        if (frame_count - f0 != 16'd2 || upd_count - u0 != 2) begin
            errors++; $display("FAIL t4_frames: frames=%0d pulses=%0d, required 2 2", frame_count - f0, upd_count - u0);
        end
        read0(12, 10, c);
        checks++;
        if (c !== 4'd11) begin
            errors++; $display("FAIL t4_read: fb_color=%0d, required 11", c);
        end
    endtask

    task automatic test_accept_timeout();
        int n;
        logic before_dirty;
        logic [15:0] f0;
        logic [3:0] c;
        drv_auto = 1'b0;
        f0 = frame_count;
        write0(1, 1, 7);
        wait_pulse0(20, "t5");
        checks++;
        if (dirty !== 1'b0) begin
            errors++; $display("FAIL t5_clr: dirty=%0b at strobe, required 0", dirty);
        end
        n = 0;
        before_dirty = 1'b0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (lcd_update) break;
            before_dirty = dirty;
        end
        checks++;
        if (n != ACCEPT_TIMEOUT + 1 || before_dirty !== 1'b1) begin
            errors++; $display("FAIL t5_restrobe: gap=%0d dirty_before=%0b, required %0d 1", n, before_dirty, ACCEPT_TIMEOUT + 1);
        end
        write0(60, 0, 3);
        write0(0, 32, 3);
        checks++;
        if (dirty !== 1'b0) begin
            errors++; $display("FAIL t5_oor_dirty: dirty=%0b, required 0", dirty);
        end
        read0(1, 1, c);
        checks++;
        if (c !== 4'd7) begin
            errors++; $display("FAIL t5_read: fb_color=%0d, required 7", c);
        end
        read0(60, 0, c);
        checks++;
        if (c !== 4'd0) begin
            errors++; $display("FAIL t5_oor_x: fb_color=%0d, required 0", c);
        end
        read0(0, 32, c);
        checks++;
        if (c !== 4'd0) begin
            errors++; $display("FAIL t5_oor_y: fb_color=%0d, required 0", c);
        end
        drv_auto = 1'b1;
        wait_idle0(300, "t5");
        checks++;
        if (frame_count - f0 != 16'd1) begin
            errors++; $display("FAIL t5_frames: frames=%0d, required 1", frame_count - f0);
        end
    endtask

    task automatic test_manual_flush();
        int n;
        for (int i = 0; i < 10; i++) write1(i, 5, i);
        repeat (50) @(negedge clk);
        checks++;
        if (n_upd_count != 0 || n_dirty !== 1'b1 || n_busy !== 1'b0) begin
            errors++; $display("FAIL t3_noflush: pulses=%0d dirty=%0b busy=%0b, required 0 1 0", n_upd_count, n_dirty, n_busy);
        end
        @(negedge clk); n_flush = 1'b1;
        @(negedge clk); n_flush = 1'b0;
        n = 0;
        while (!(n_busy == 1'b0 && n_dirty == 1'b0) && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (n_upd_count != 1 || n_frame_count !== 16'd1) begin
            errors++; $display("FAIL t3_flush: pulses=%0d frames=%0d, required 1 1", n_upd_count, n_frame_count);
        end
        @(negedge clk); n_flush = 1'b1;
        @(negedge clk); n_flush = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (n_upd_count != 1 || n_busy !== 1'b0) begin
            errors++; $display("FAIL t3_clean_flush: pulses=%0d busy=%0b, required 1 0", n_upd_count, n_busy);
        end
        write1(0, 6, 2);
        repeat (30) @(negedge clk);
        checks++;
        if (n_upd_count != 1 || n_dirty !== 1'b1) begin
            errors++; $display("FAIL t3_consumed: pulses=%0d dirty=%0b, required 1 1", n_upd_count, n_dirty);
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        logic [3:0] c;
        @(negedge clk);
        clear_req = 1'b1; clear_color = 4'd4;
        @(negedge clk);
        clear_req = 1'b0;
        n = 0;
        while (wr_ready && n < 10) begin @(negedge clk); n++; end
        repeat (100) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, wr_ready, lcd_update, dirty, frame_count, fb_color} !== {1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 4'd0}) begin
            errors++;
            $display("FAIL t6_reset: busy=%0b wr_ready=%0b upd=%0b dirty=%0b frames=%0d color=%0d, required 0 1 0 0 0 0",
                     busy, wr_ready, lcd_update, dirty, frame_count, fb_color);
        end
        @(negedge clk);
        rst = 1'b0;
        read0(0, 0, c);
        checks++;
        if (c !== 4'd4) begin
            errors++; $display("FAIL t6_cell0: fb_color=%0d, required 4", c);
        end
        read0(50, 0, c);
        checks++;
        if (c !== 4'd4) begin
            errors++; $display("FAIL t6_cell50: fb_color=%0d, required 4", c);
        end
        read0(0, 20, c);
        checks++;
        if (c !== 4'd9) begin
            errors++; $display("FAIL t6_uncleared: fb_color=%0d, required 9", c);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || dirty !== 1'b0) begin
            errors++; $display("FAIL t6_quiet: busy=%0b dirty=%0b, required 0 0", busy, dirty);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_write_refresh();
        test_clear();
        test_write_during_done();
        test_accept_timeout();
        test_manual_flush();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
